// File: rtl/lane_steer_filter.sv
`default_nettype none
// ============================================================================
// Module  : lane_steer_filter
// Brief   : Rescales/saturates CNN lane results, smooths them with a moving
//           average and classifies steering direction with hysteresis.
//           Optional stale-input watchdog: define LANE_STALE_WDT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module lane_steer_filter #(
  parameter int RESULT_W     = 48,
  parameter int FRAC_SHIFT   = 16,
  parameter int OUT_W        = 16,
  parameter int AVG_LOG2     = 2,
  parameter int DEADBAND     = 64,
  parameter int HYST         = 16,
  parameter int STALE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_result_valid,
  input  logic [RESULT_W-1:0] i_result_data,
  input  logic                i_steer_ready,
  output logic                o_steer_valid,
  output logic [OUT_W-1:0]    o_steer_value,
  output logic [1:0]          o_steer_dir,
  output logic                o_window_full,
  output logic                o_sat_flag,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int c_win   = 2**AVG_LOG2;
  localparam int c_sum_w = OUT_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] c_cnt_full = (AVG_LOG2+1)'(c_win);
  localparam logic [1:0] c_dir_straight = 2'b00;
  localparam logic [1:0] c_dir_left     = 2'b01;
  localparam logic [1:0] c_dir_right    = 2'b10;
  localparam logic signed [RESULT_W-1:0] c_sat_max = {{(RESULT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RESULT_W-1:0] c_sat_min = {{(RESULT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] c_enter_pos = OUT_W'(DEADBAND);
  localparam logic signed [OUT_W-1:0] c_enter_neg = OUT_W'(-DEADBAND);
  localparam logic signed [OUT_W-1:0] c_exit_pos  = OUT_W'(DEADBAND - HYST);
  localparam logic signed [OUT_W-1:0] c_exit_neg  = OUT_W'(HYST - DEADBAND);

  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_ACCUM, S_DECIDE} state_t;
  state_t r_state, w_next;

  logic                       r_prev_valid;
  logic signed [RESULT_W-1:0] r_raw;
  logic signed [OUT_W-1:0]    r_s;
  logic signed [OUT_W-1:0]    r_win [c_win];
  logic signed [c_sum_w-1:0]  r_sum;
  logic [AVG_LOG2:0]          r_count;
  logic [AVG_LOG2-1:0]        r_wr_ptr;
  logic                       r_valid, r_sat, r_overrun;
  logic signed [OUT_W-1:0]    r_value;
  logic [1:0]                 r_dir;

  logic                       w_rise, w_busy, w_full, w_stale;
  logic signed [RESULT_W-1:0] w_shift;
  logic signed [OUT_W-1:0]    w_avg;
  logic [1:0]                 w_dir;

  assign w_rise  = i_result_valid & ~r_prev_valid;
  assign w_busy  = (r_state != S_IDLE);
  assign w_full  = (r_count == c_cnt_full);
  assign w_shift = r_raw >>> FRAC_SHIFT;
  // Pass the fresh sample through until the window has filled once.
  assign w_avg   = w_full ? OUT_W'(r_sum >>> AVG_LOG2) : r_s;

`ifdef LANE_STALE_WDT_EN
  localparam int c_wdt_w = $clog2(STALE_CYCLES + 1);
  logic [c_wdt_w-1:0] r_wdt;

  assign w_stale = (r_state == S_IDLE) && !w_rise && (r_wdt == c_wdt_w'(STALE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || w_rise) begin
      r_wdt <= '0;
    end else if (r_state == S_IDLE) begin
      r_wdt <= w_stale ? '0 : r_wdt + c_wdt_w'(1);
    end
  end
`else
  logic w_unused_stale;
  assign w_unused_stale = (STALE_CYCLES == 0);
  assign w_stale        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_rise) w_next = S_SCALE;
      S_SCALE:  w_next = S_ACCUM;
      S_ACCUM:  w_next = S_DECIDE;
      S_DECIDE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_dir = r_dir;
    case (r_dir)
      c_dir_left: begin
        if (w_avg > c_enter_pos)     w_dir = c_dir_right;
        else if (w_avg > c_exit_neg) w_dir = c_dir_straight;
      end
      c_dir_right: begin
        if (w_avg < c_enter_neg)     w_dir = c_dir_left;
        else if (w_avg < c_exit_pos) w_dir = c_dir_straight;
      end
      default: begin
        if (w_avg < c_enter_neg)      w_dir = c_dir_left;
        else if (w_avg > c_enter_pos) w_dir = c_dir_right;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_raw        <= '0;
      r_s          <= '0;
      r_sum        <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_valid      <= 1'b0;
      r_sat        <= 1'b0;
      r_overrun    <= 1'b0;
      r_value      <= '0;
      r_dir        <= c_dir_straight;
      for (int i = 0; i < c_win; i++) r_win[i] <= '0;
    end else begin
      r_prev_valid <= i_result_valid;
      r_overrun    <= w_rise && w_busy;
      if (r_valid && i_steer_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_raw <= i_result_data;
          end else if (w_stale) begin
            r_sum    <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < c_win; i++) r_win[i] <= '0;
            r_value  <= '0;
            r_dir    <= c_dir_straight;
            r_valid  <= 1'b1;
            if (r_valid && !i_steer_ready) r_overrun <= 1'b1;
          end
        end
        S_SCALE: begin
          if (w_shift > c_sat_max) begin
            r_s   <= c_sat_max[OUT_W-1:0];
            r_sat <= 1'b1;
          end else if (w_shift < c_sat_min) begin
            r_s   <= c_sat_min[OUT_W-1:0];
            r_sat <= 1'b1;
          end else begin
            r_s   <= w_shift[OUT_W-1:0];
          end
        end
        S_ACCUM: begin
          r_sum           <= r_sum + c_sum_w'(r_s) - c_sum_w'(r_win[r_wr_ptr]);
          r_win[r_wr_ptr] <= r_s;
          r_wr_ptr        <= r_wr_ptr + AVG_LOG2'(1);
          if (!w_full) r_count <= r_count + (AVG_LOG2+1)'(1);
        end
        S_DECIDE: begin
          // A same-cycle transfer frees the slot, so only an unaccepted output counts as lost.
          r_value <= w_avg;
          r_dir   <= w_dir;
          r_valid <= 1'b1;
          if (r_valid && !i_steer_ready) r_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_steer_valid = r_valid;
  assign o_steer_value = r_value;
  assign o_steer_dir   = r_dir;
  assign o_window_full = w_full;
  assign o_sat_flag    = r_sat;
  assign o_overrun     = r_overrun;
  assign o_busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_lane_steer_filter.sv
`default_nettype none
// Self-checking bench for lane_steer_filter: vector table plus corner-case sequences.
module tb_lane_steer_filter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_result_valid = 1'b0;
  logic [47:0]        i_result_data = '0;
  logic               i_steer_ready = 1'b1;
  logic               o_steer_valid;
  logic signed [15:0] o_steer_value;
  logic [1:0]         o_steer_dir;
  logic               o_window_full, o_sat_flag, o_overrun, o_busy;

  lane_steer_filter #(.STALE_CYCLES(1000)) dut (
    .clk(clk), .rst(rst),
    .i_result_valid(i_result_valid), .i_result_data(i_result_data),
    .i_steer_ready(i_steer_ready),
    .o_steer_valid(o_steer_valid), .o_steer_value(o_steer_value),
    .o_steer_dir(o_steer_dir), .o_window_full(o_window_full),
    .o_sat_flag(o_sat_flag), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] ST = 2'b00, LF = 2'b01, RT = 2'b10;

  typedef struct {
    bit          do_rst;
    longint      data;
    int          val;
    logic [1:0]  dir;
    bit          full;
    bit          sat;
  } vec_t;

  typedef struct {
    logic signed [15:0] val;
    logic [1:0]         dir;
    bit                 full;
    bit                 sat;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0, n_xfer = 0, n_ovr = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_steer_valid && i_steer_ready) begin
      exp_t e;
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(o_steer_value), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("value", 64'(o_steer_value), 64'(e.val));
        chk("dir",   64'(o_steer_dir),   64'(e.dir));
        chk("full",  64'(o_window_full), 64'(e.full));
        chk("sat",   64'(o_sat_flag),    64'(e.sat));
        if (e.cyc != 0) chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (!rst && o_overrun) n_ovr++;
  end

  function automatic vec_t v(bit r, longint d, int val, logic [1:0] dir, bit f, bit s);
    vec_t x;
    x.do_rst = r; x.data = d; x.val = val; x.dir = dir; x.full = f; x.sat = s;
    return x;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; i_result_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One-cycle result pulse; optionally records the expected delivered output.
  task automatic send(input longint d, input bit push, input int val, input logic [1:0] dir,
                      input bit f, input bit s, input bit lat);
    exp_t e;
    @(posedge clk); #1;
    i_result_valid = 1'b1;
    i_result_data  = 48'(d);
    if (push) begin
      e.val = 16'(val); e.dir = dir; e.full = f; e.sat = s; e.cyc = lat ? cyc + 4 : 0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1 i_result_valid = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int ovr0, x0;

    // Reset and check idle outputs
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(o_steer_valid), 64'd0);
    chk("rst_value", 64'(o_steer_value), 64'd0);
    chk("rst_dir",   64'(o_steer_dir),   64'(ST));
    chk("rst_full",  64'(o_window_full), 64'd0);
    chk("rst_sat",   64'(o_sat_flag),    64'd0);
    chk("rst_busy",  64'(o_busy),        64'd0);

    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 100 << 16, 100, RT, i == 3, 0));
    tbl.push_back(v(1, 64'sh7FFF_FFFF_FFFF, 32767, RT, 0, 1));
    tbl.push_back(v(0, -(64'sd1 <<< 40), -32768, LF, 0, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(i == 0, 100 << 16, 100, RT, i == 3, 0));
    tbl.push_back(v(0, 60 << 16, 90, RT, 1, 0));
    tbl.push_back(v(0, 60 << 16, 80, RT, 1, 0));
    tbl.push_back(v(0, 60 << 16, 70, RT, 1, 0));
    tbl.push_back(v(0, 60 << 16, 60, RT, 1, 0));
    tbl.push_back(v(0, 40 << 16, 55, RT, 1, 0));
    tbl.push_back(v(0, 40 << 16, 50, RT, 1, 0));
    tbl.push_back(v(0, 40 << 16, 45, ST, 1, 0));
    tbl.push_back(v(0, 40 << 16, 40, ST, 1, 0));
    tbl.push_back(v(0, -300 << 16, -45, ST, 1, 0));
    tbl.push_back(v(0, -300 << 16, -130, LF, 1, 0));
    tbl.push_back(v(0, 0, -140, LF, 1, 0));
    tbl.push_back(v(0, 0, -150, LF, 1, 0));
    tbl.push_back(v(0, 1000 << 16, 175, RT, 1, 0));
    tbl.push_back(v(1, -64 << 16, -64, ST, 0, 0));
    tbl.push_back(v(0, 65 << 16, 65, RT, 0, 0));
    tbl.push_back(v(0, 48 << 16, 48, RT, 0, 0));
    tbl.push_back(v(0, 47 << 16, 24, ST, 1, 0));

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      send(tbl[i].data, 1, tbl[i].val, tbl[i].dir, tbl[i].full, tbl[i].sat, 1);
    end
    chk("table_no_overrun", 64'(n_ovr), 64'd0);

    // Level valid held high for 10 cycles yields one sample
    do_reset();
    x0 = n_xfer;
    @(posedge clk); #1;
    i_result_valid = 1'b1; i_result_data = 48'(80 << 16);
    begin
      exp_t e;
      e.val = 16'sd80; e.dir = RT; e.full = 0; e.sat = 0; e.cyc = cyc + 4;
      exp_q.push_back(e);
    end
    repeat (10) @(posedge clk);
    #1 i_result_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("held_valid_xfers", 64'(n_xfer - x0), 64'd1);

    // Rising edge while busy is dropped; window keeps only real samples
    do_reset();
    ovr0 = n_ovr;
    @(posedge clk); #1;
    i_result_valid = 1'b1; i_result_data = 48'(70 << 16);
    begin
      exp_t e;
      e.val = 16'sd70; e.dir = RT; e.full = 0; e.sat = 0; e.cyc = cyc + 4;
      exp_q.push_back(e);
    end
    @(posedge clk); #1 i_result_valid = 1'b0;
    @(posedge clk); #1 i_result_valid = 1'b1; i_result_data = 48'(-500 << 16);
    @(posedge clk); #1 i_result_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("busy_drop_overrun", 64'(n_ovr - ovr0), 64'd1);
    send(10 << 16, 1, 10, ST, 0, 0, 1);
    send(10 << 16, 1, 10, ST, 0, 0, 1);
    send(10 << 16, 1, 25, ST, 1, 0, 1);

    // Pending output overwritten while downstream stalls
    do_reset();
    ovr0 = n_ovr;
    x0 = n_xfer;
    i_steer_ready = 1'b0;
    send(200 << 16, 0, 0, ST, 0, 0, 0);
    @(negedge clk);
    chk("stall_valid", 64'(o_steer_valid), 64'd1);
    chk("stall_hold",  64'(o_steer_value), 64'(16'sd200));
    send(-300 << 16, 1, -300, LF, 0, 0, 0);
    @(negedge clk);
    chk("overwrite_value",   64'(o_steer_value), 64'(-16'sd300));
    chk("overwrite_overrun", 64'(n_ovr - ovr0),  64'd1);
    @(posedge clk); #1 i_steer_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("overwrite_xfers", 64'(n_xfer - x0), 64'd1);

    // Reset while in S_ACCUM aborts the sample
    do_reset();
    @(posedge clk); #1 i_result_valid = 1'b1; i_result_data = 48'(500 << 16);
    @(posedge clk); #1 i_result_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy",  64'(o_busy),        64'd0);
    chk("abort_valid", 64'(o_steer_valid), 64'd0);
    send(30 << 16, 1, 30, ST, 0, 0, 1);
    send(30 << 16, 1, 30, ST, 0, 0, 1);
    send(30 << 16, 1, 30, ST, 0, 0, 1);
    send(30 << 16, 1, 30, ST, 1, 0, 1);

`ifdef LANE_STALE_WDT_EN
    // Stale input flushes the window and reports a neutral decision
    do_reset();
    send(100 << 16, 1, 100, RT, 0, 0, 1);
    begin
      exp_t e;
      e.val = 16'sd0; e.dir = ST; e.full = 0; e.sat = 0; e.cyc = 0;
      exp_q.push_back(e);
    end
    repeat (1010) @(posedge clk);
`endif

    repeat (4) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
